cacheline_mem_arbiter: RTL and testbench

Shares the single 64-bit burst SDRAM memory port between the instruction cache (read-only) and the data cache (read/write), one cacheline transaction at a time. It serializes 256-bit line writes into four 64-bit write beats and collects four tagged read-return beats into a 256-bit line. Round-robin arbitration prevents either requester from being starved. It sits between the two caches and the top-level memory port.

---
 rtl/cacheline_mem_arbiter_pkg.sv | 28 ++
 rtl/cacheline_mem_arbiter_if.sv | 41 ++++
 rtl/cacheline_mem_arbiter_rr_arbiter2.sv | 36 +++
 rtl/cacheline_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types and constants for the cacheline memory arbiter.
package mem_arb_pkg;

   localparam int BURST_LEN        = 4;
   localparam int BEAT_W           = 64;
   localparam int LINE_WIDTH       = BURST_LEN * BEAT_W;
   localparam int LINE_OFFSET_BITS = 5;
   localparam int BEAT_IDX_W       = $clog2(BURST_LEN);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_REQ,
      READ_WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      CLIENT_I,
      CLIENT_D
   } client_t;

   // Align an address down to the start of its cacheline.
   function automatic logic [31:0] line_base(input logic [31:0] addr);
      return {addr[31:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
   endfunction

endpackage

// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of the two cache client ports and the burst memory port.
// The master side is the arbiter; the slave side is the caches plus memory.
interface cacheline_mem_arbiter_if;
   import mem_arb_pkg::*;

   logic [31:0]           i_addr;
   logic                  i_read;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic [31:0]           d_addr;
   logic                  d_read;
   logic                  d_write;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic [31:0]           mem_addr;
   logic                  mem_read;
   logic                  mem_write;
   logic [BEAT_W-1:0]     mem_wdata;
   logic                  mem_ready;
   logic [BEAT_W-1:0]     mem_rdata;
   logic [31:0]           mem_raddr;
   logic                  mem_rvalid;

   modport master (
      input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
             mem_ready, mem_rdata, mem_raddr, mem_rvalid,
      output i_rdata, i_resp, d_rdata, d_resp,
             mem_addr, mem_read, mem_write, mem_wdata
   );

   modport slave (
      output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
             mem_ready, mem_rdata, mem_raddr, mem_rvalid,
      input  i_rdata, i_resp, d_rdata, d_resp,
             mem_addr, mem_read, mem_write, mem_wdata
   );

endinterface

// File: rtl/cacheline_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: a tie goes to the client not served last.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    req_i,
   input  logic    req_d,
   input  logic    take,
   output logic    gnt_valid,
   output client_t gnt
);

   client_t last_grant;

   // Pick the winner from the current requests and the previous winner.
   always_comb begin
      gnt_valid = req_i | req_d;
      gnt       = CLIENT_I;
      if (req_i && req_d) begin
         gnt = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
      end else if (req_d) begin
         gnt = CLIENT_D;
      end
   end

   // Remember who won, only when the grant is actually taken; starts at D so the first tie goes to I.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= CLIENT_D;
      end else if (take && gnt_valid) begin
         last_grant <= gnt;
      end
   end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one 64-bit burst memory port between the I-cache and D-cache,
// one cacheline at a time: writes go out as four beats, reads collect four
// address-tagged return beats into a line.
module cacheline_mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   cacheline_mem_arbiter_if.master bus
);

   arb_state_t            state;
   arb_state_t            state_next;
   logic [BEAT_IDX_W-1:0] beat;
   logic [31:0]           line_addr;
   client_t               owner;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic [LINE_WIDTH-1:0] i_rdata_q;
   logic [LINE_WIDTH-1:0] d_rdata_q;
   logic                  gnt_valid;
   client_t               gnt;
   logic                  last_beat;
   logic                  rd_hit;
   logic                  gnt_write;

   rr_arbiter2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .req_i     (bus.i_read),
      .req_d     (bus.d_read | bus.d_write),
      .take      (state == IDLE),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   assign last_beat = (beat == BEAT_IDX_W'(BURST_LEN - 1));
   // Return beats tagged with another line belong to nobody here and are dropped.
   assign rd_hit    = bus.mem_rvalid && (bus.mem_raddr == line_addr);
   assign gnt_write = (gnt == CLIENT_D) && bus.d_write;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (gnt_valid) state_next = gnt_write ? WRITE : READ_REQ;
         WRITE:     if (bus.mem_ready && last_beat) state_next = RESP;
         READ_REQ:  if (bus.mem_ready) state_next = READ_WAIT;
         READ_WAIT: if (rd_hit && last_beat) state_next = RESP;
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Latch the granted transaction, count beats and assemble returned lines.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat      <= '0;
         line_addr <= '0;
         owner     <= CLIENT_I;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  owner     <= gnt;
                  beat      <= '0;
                  line_addr <= line_base((gnt == CLIENT_I) ? bus.i_addr : bus.d_addr);
                  if (gnt_write) wdata_q <= bus.d_wdata;
               end
            end
            WRITE: begin
               if (bus.mem_ready) beat <= beat + 1'b1;
            end
            READ_WAIT: begin
               if (rd_hit) begin
                  beat <= beat + 1'b1;
                  if (owner == CLIENT_I) begin
                     i_rdata_q[BEAT_W*int'(beat) +: BEAT_W] <= bus.mem_rdata;
                  end else begin
                     d_rdata_q[BEAT_W*int'(beat) +: BEAT_W] <= bus.mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Memory port and completion pulses decoded from registered state only.
   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.i_resp    = 1'b0;
      bus.d_resp    = 1'b0;
      case (state)
         WRITE: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = line_addr;
            bus.mem_wdata = wdata_q[BEAT_W*int'(beat) +: BEAT_W];
         end
         READ_REQ: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = line_addr;
         end
         RESP: begin
            bus.i_resp = (owner == CLIENT_I);
            bus.d_resp = (owner == CLIENT_D);
         end
         default: ;
      endcase
   end

   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed + randomized bench for cacheline_mem_arbiter with a line-level
// memory model and a simple round-robin grant model.
module tb_cacheline_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int LW = LINE_WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cacheline_mem_arbiter_if bus();

   cacheline_mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [LW-1:0] line_mem [logic [31:0]];
   client_t       model_last;
   logic [LW-1:0] exp_i_rdata;
   logic [LW-1:0] exp_d_rdata;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] base_of(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   function automatic logic [LW-1:0] mem_line(input logic [31:0] b);
      logic [LW-1:0] l;
      if (line_mem.exists(b)) return line_mem[b];
      for (int k = 0; k < BURST_LEN; k++) l[64*k +: 64] = {b ^ 32'hA5A5_0000, b + 32'(k)};
      return l;
   endfunction

   // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
   function automatic client_t predict(input logic pi, input logic pd);
      if (pi && pd) return (model_last == CLIENT_I) ? CLIENT_D : CLIENT_I;
      return pi ? CLIENT_I : CLIENT_D;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, " mem_read"},  LW'(bus.mem_read),  '0);
      chk({tag, " mem_write"}, LW'(bus.mem_write), '0);
      chk({tag, " mem_addr"},  LW'(bus.mem_addr),  '0);
      chk({tag, " mem_wdata"}, LW'(bus.mem_wdata), '0);
      chk({tag, " resp"},      LW'({bus.i_resp, bus.d_resp}), '0);
      chk({tag, " i_rdata"},   bus.i_rdata, '0);
      chk({tag, " d_rdata"},   bus.d_rdata, '0);
   endtask

   // Act as memory for one transaction; called on a negedge, returns on the negedge after resp.
   task automatic serve(input int stall_beat, input int stall_len, input bit junk, input bit gaps,
                        input bit drop, input int abort_beat, output client_t who);
      client_t       g;
      logic [31:0]   addr;
      bit            wr;
      logic [LW-1:0] wline, rline;
      int            n, b, stall;
      who = CLIENT_I;
      n = 0;
      while (!(bus.mem_read || bus.mem_write) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("txn_start", LW'(bus.mem_read || bus.mem_write), LW'(1));
      if (!(bus.mem_read || bus.mem_write)) return;
      g = predict(bus.i_read, bus.d_read || bus.d_write);
      model_last = g;
      addr = (g == CLIENT_I) ? bus.i_addr : bus.d_addr;
      wr = (g == CLIENT_D) && bus.d_write;
      chk("grant_addr", LW'(bus.mem_addr), LW'(base_of(addr)));
      chk("op_write", LW'(bus.mem_write), LW'(wr));
      rline = '0;
      if (wr) begin
         wline = bus.d_wdata;
         b = 0; stall = 0; n = 0;
         while (b < BURST_LEN && n < 100) begin
            chk("wr_valid", LW'(bus.mem_write), LW'(1));
            chk("wr_addr", LW'(bus.mem_addr), LW'(base_of(addr)));
            chk("wr_beat", LW'(bus.mem_wdata), LW'(wline[64*b +: 64]));
            if (b == abort_beat) begin
               rst = 1'b0;
               #1;
               chk_reset("abort");
               model_last = CLIENT_D;
               exp_i_rdata = '0;
               exp_d_rdata = '0;
               bus.d_write = 1'b0;
               bus.mem_ready = 1'b0;
               @(negedge clk);
               rst = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  chk("abort_no_resp", LW'({bus.i_resp, bus.d_resp}), '0);
                  chk("abort_port_idle", LW'({bus.mem_read, bus.mem_write}), '0);
               end
               return;
            end
            if (b == stall_beat && stall < stall_len) begin
               bus.mem_ready = 1'b0;
               stall++;
            end else begin
               bus.mem_ready = 1'b1;
               b++;
            end
            @(negedge clk);
            n++;
         end
         bus.mem_ready = 1'b0;
         line_mem[base_of(addr)] = wline;
      end else begin
         n = gaps ? $urandom_range(0, 2) : 0;
         for (int k = 0; k < n; k++) begin
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_raddr  = base_of(addr);
            bus.mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
            @(negedge clk);
            chk("rd_cmd_hold", LW'({bus.mem_read, bus.mem_addr}), LW'({1'b1, base_of(addr)}));
         end
         bus.mem_ready  = 1'b1;
         bus.mem_rvalid = 1'b0;
         @(negedge clk);
         bus.mem_ready = 1'b0;
         chk("rd_single_cmd", LW'(bus.mem_read), '0);
         rline = mem_line(base_of(addr));
         for (int k = 0; k < BURST_LEN; k++) begin
            if (gaps) begin
               repeat ($urandom_range(0, 2)) begin
                  bus.mem_rvalid = 1'b0;
                  @(negedge clk);
                  chk("rd_no_early_resp", LW'({bus.i_resp, bus.d_resp}), '0);
               end
            end
            if (junk && k == 2) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_raddr  = 32'hDEAD_0000;
               bus.mem_rdata  = {$urandom, $urandom};
               @(negedge clk);
               chk("rd_junk_no_resp", LW'({bus.i_resp, bus.d_resp}), '0);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_raddr  = base_of(addr);
            bus.mem_rdata  = rline[64*k +: 64];
            @(negedge clk);
            if (k < BURST_LEN - 1) chk("rd_no_early_resp", LW'({bus.i_resp, bus.d_resp}), '0);
         end
         bus.mem_rvalid = 1'b0;
         if (g == CLIENT_I) exp_i_rdata = rline;
         else exp_d_rdata = rline;
      end
      chk("resp_i", LW'(bus.i_resp), LW'(g == CLIENT_I));
      chk("resp_d", LW'(bus.d_resp), LW'(g == CLIENT_D));
      chk("i_rdata", bus.i_rdata, exp_i_rdata);
      chk("d_rdata", bus.d_rdata, exp_d_rdata);
      who = bus.d_resp ? CLIENT_D : CLIENT_I;
      if (drop) begin
         if (g == CLIENT_I) bus.i_read = 1'b0;
         else begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
         end
      end
      @(negedge clk);
      chk("resp_pulse", LW'({bus.i_resp, bus.d_resp}), '0);
      chk("port_idle", LW'({bus.mem_read, bus.mem_write}), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      client_t who, prev;
      int      ni, kind;
      bus.i_addr = '0; bus.i_read = 1'b0;
      bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.mem_raddr = '0; bus.mem_rvalid = 1'b0;
      model_last = CLIENT_D;
      exp_i_rdata = '0;
      exp_d_rdata = '0;

      // Power-on reset values.
      @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;

      // I-cache read of a known line.
      line_mem[32'h0000_1040] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      bus.i_addr = 32'h0000_1044;
      bus.i_read = 1'b1;
      serve(-1, 0, 1'b0, 1'b0, 1'b1, -1, who);
      chk("t1_line", bus.i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // D-cache write with a three-cycle stall on beat 2.
      bus.d_addr  = 32'h0000_2000;
      bus.d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      bus.d_write = 1'b1;
      serve(2, 3, 1'b0, 1'b0, 1'b1, -1, who);
      chk("t2_who", LW'(who), LW'(CLIENT_D));

      // Reset while idle, then two ties in a row: I wins both.
      rst = 1'b0;
      #1;
      chk_reset("idle_reset");
      model_last = CLIENT_D;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      @(negedge clk);
      rst = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         bus.i_addr = $urandom;
         bus.d_addr = bus.i_addr ^ 32'h0001_0000;
         bus.i_read = 1'b1;
         bus.d_read = 1'b1;
         serve(-1, 0, 1'b0, 1'b1, 1'b1, -1, who);
         chk("tie_first_i", LW'(who), LW'(CLIENT_I));
         serve(-1, 0, 1'b0, 1'b1, 1'b1, -1, who);
         chk("tie_second_d", LW'(who), LW'(CLIENT_D));
      end

      // Foreign-tagged beat interleaved between beats 1 and 2.
      bus.i_addr = $urandom;
      bus.i_read = 1'b1;
      serve(-1, 0, 1'b1, 1'b1, 1'b1, -1, who);

      // Reset during write beat 2, then a normal D read of the earlier line.
      bus.d_addr  = 32'h0000_3000;
      bus.d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.d_write = 1'b1;
      serve(-1, 0, 1'b0, 1'b0, 1'b1, 2, who);
      bus.d_addr = 32'h0000_2008;
      bus.d_read = 1'b1;
      serve(-1, 0, 1'b0, 1'b0, 1'b1, -1, who);
      chk("post_abort_line", bus.d_rdata, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

      // D holds its read while I issues three back-to-back reads.
      bus.d_addr = 32'h0004_0000;
      bus.d_read = 1'b1;
      bus.i_addr = 32'h0005_0000;
      bus.i_read = 1'b1;
      ni = 0;
      prev = CLIENT_D;
      for (int t = 0; t < 6; t++) begin
         serve(-1, 0, 1'b0, 1'b1, 1'b0, -1, who);
         chk("alternate", LW'(who != prev), LW'(1));
         prev = who;
         if (who == CLIENT_I) begin
            ni++;
            if (ni < 3) bus.i_addr = bus.i_addr + 32'h40;
            else bus.i_read = 1'b0;
         end
      end
      bus.d_read = 1'b0;
      chk("fair_i_count", LW'(ni), LW'(3));

      // Randomized mix of single and simultaneous requests.
      for (int r = 0; r < 10; r++) begin
         kind = $urandom_range(0, 3);
         bus.i_addr = $urandom;
         bus.d_addr = bus.i_addr ^ 32'h0000_1000;
         for (int k = 0; k < 8; k++) bus.d_wdata[32*k +: 32] = $urandom;
         bus.i_read  = (kind == 0 || kind == 3);
         bus.d_read  = (kind == 1);
         bus.d_write = (kind == 2 || kind == 3);
         serve($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, -1, who);
         if (kind == 3) begin
            serve($urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b1, 1'b1, -1, who);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
